// File: rtl/seq_divider_version11_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_version11_pkg;

    // Default operand width; the dividend is twice this wide.
    localparam int unsigned DEFAULT_WIDTH = 512;

    // Controller states.
    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Step counter width: wide enough to hold WIDTH without wrapping.
    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_version11_div_step.sv
// One restoring division step: shift in the next dividend bit, then
// subtract the divisor if the shifted remainder is large enough.
module seq_divider_version11_div_step
    import seq_divider_version11_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Compare at WIDTH+1 bits; the difference fits in WIDTH bits because the
    // subtraction only happens when shifted >= divisor and rem_in < divisor.
    always_comb begin
        shifted = {rem_in, q_msb};
        q_bit   = (shifted >= {1'b0, divisor});
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider_version11.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, valid/ready on both sides.
module seq_divider_version11
    import seq_divider_version11_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int unsigned CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state;
    logic [CW-1:0]    count;
    // Partial remainder. Its extra top bit is always zero between steps
    // (remainder stays below the divisor), so only WIDTH bits are stored.
    logic [WIDTH-1:0] rem_r;
    // Quotient shift register; low dividend bits shift out as quotient bits shift in.
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] divisor_r;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] dvd_hi;
    logic [WIDTH-1:0] dvd_lo;
    logic             accept;

    seq_divider_version11_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_r),
        .q_msb   (quo_r[WIDTH-1]),
        .divisor (divisor_r),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // Split the dividend and form the next quotient shift value.
    always_comb begin
        dvd_hi   = dividend[2*WIDTH-1:WIDTH];
        dvd_lo   = dividend[WIDTH-1:0];
        step_quo = {quo_r[WIDTH-2:0], step_bit};
        accept   = in_valid && in_ready;
    end

    // Controller, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            count       <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            divisor_r   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        in_ready  <= 1'b0;
                        divisor_r <= divisor;
                        if (divisor == '0) begin
                            state       <= StDone;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dvd_lo;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else if (dvd_hi >= divisor) begin
                            // Quotient would need more than WIDTH bits.
                            state       <= StDone;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end else begin
                            state <= StBusy;
                            rem_r <= dvd_hi;
                            quo_r <= dvd_lo;
                            count <= '0;
                        end
                    end
                end
                StBusy: begin
                    rem_r <= step_rem;
                    quo_r <= step_quo;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state       <= StDone;
                        out_valid   <= 1'b1;
                        quotient    <= step_quo;
                        remainder   <= step_rem;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                StDone: begin
                    // in_ready only rises the cycle after the output handshake.
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_version11.sv
// Scoreboard bench for the sequential divider (WIDTH=8 random/directed, plus
// one WIDTH=512 round-trip of a multiplier product).
module tb_seq_divider_version11;

    localparam int unsigned W = 8;
    localparam int unsigned WB = 512;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } res_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    logic            b_in_valid = 1'b0;
    logic            b_in_ready;
    logic [2*WB-1:0] b_dividend = '0;
    logic [WB-1:0]   b_divisor = '0;
    logic            b_out_valid;
    logic [WB-1:0]   b_quotient;
    logic [WB-1:0]   b_remainder;
    logic            b_dbz;
    logic            b_ovf;

    int total = 0;
    int bad = 0;
    int ready_mode = 1;  // 0 random, 1 always ready, 2 never ready
    res_t sb[$];

    always #5 clk = ~clk;

    seq_divider_version11 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    seq_divider_version11 #(.WIDTH(WB)) dut_big (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .dividend(b_dividend), .divisor(b_divisor), .out_valid(b_out_valid),
        .out_ready(1'b1), .quotient(b_quotient), .remainder(b_remainder),
        .div_by_zero(b_dbz), .overflow(b_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the exception rules.
    function automatic res_t model(input int unsigned dvd, input int unsigned dvs);
        res_t r;
        if (dvs == 0) begin
            r.q = 8'hFF; r.r = 8'(dvd % 256); r.dbz = 1'b1; r.ovf = 1'b0;
        end else if (dvd / dvs > 255) begin
            r.q = 8'hFF; r.r = 8'h00; r.dbz = 1'b0; r.ovf = 1'b1;
        end else begin
            r.q = 8'(dvd / dvs); r.r = 8'(dvd % dvs); r.dbz = 1'b0; r.ovf = 1'b0;
        end
        return r;
    endfunction

    // Monitor: drives out_ready, pops the scoreboard on handshakes, checks stability.
    res_t prev_out;
    logic prev_valid = 1'b0;
    logic prev_hs = 1'b0;
    logic prev_rst = 1'b1;
    always @(negedge clk) begin
        res_t cur;
        res_t exp;
        cur = '{q: quotient, r: remainder, dbz: div_by_zero, ovf: overflow};
        case (ready_mode)
            0: out_ready = 1'($urandom_range(0, 1));
            1: out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
        if (!rst && !prev_rst) begin
            if (prev_valid && !prev_hs) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_result", 64'(cur), 64'(prev_out));
            end else if (!prev_valid && !out_valid) begin
                check("idle_result_hold", 64'(cur), 64'(prev_out));
            end
            if (out_valid) check("in_ready_low_in_done", 64'(in_ready), 64'd0);
        end
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                exp = sb.pop_front();
                check("quotient", 64'(cur.q), 64'(exp.q));
                check("remainder", 64'(cur.r), 64'(exp.r));
                check("div_by_zero", 64'(cur.dbz), 64'(exp.dbz));
                check("overflow", 64'(cur.ovf), 64'(exp.ovf));
            end
        end
        prev_out   = cur;
        prev_valid = out_valid;
        prev_hs    = out_valid && out_ready;
        prev_rst   = rst;
    end

    // Issue one operation; optionally measure edges from acceptance to out_valid.
    task automatic send(input int unsigned dvd, input int unsigned dvs, input bit wait_out,
                        output int lat);
        int guard;
        lat = -1;
        @(negedge clk);
        dividend = 16'(dvd);
        divisor  = 8'(dvs);
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd1, 64'd0);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(model(dvd, dvs));
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (!wait_out) return;
        lat = 1;
        guard = 0;
        while (guard < 200) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
            guard++;
        end
        if (!out_valid) begin
            check("output_timeout", 64'd1, 64'd0);
            lat = -1;
        end
    endtask

    initial begin
        int lat;
        res_t snap;
        logic [1023:0] prod;
        int guard;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'({quotient, remainder, div_by_zero, overflow}), 64'd0);

        // Directed latency checks, consumer always ready.
        send(100, 7, 1'b1, lat);
        check("lat_100_7", 64'(lat), 64'd9);
        send(16'h0055, 0, 1'b1, lat);
        check("lat_div_zero", 64'(lat), 64'd1);
        send(16'h1234, 8'h12, 1'b1, lat);
        check("lat_overflow", 64'(lat), 64'd1);
        send(16'h1234, 8'h13, 1'b1, lat);
        check("lat_1234_13", 64'(lat), 64'd9);

        // Backpressure: result held while out_ready stays low.
        @(posedge clk);
        #1 ready_mode = 2;
        send(100, 7, 1'b1, lat);
        check("lat_bp", 64'(lat), 64'd9);
        snap = '{q: quotient, r: remainder, dbz: div_by_zero, ovf: overflow};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_result", 64'({quotient, remainder, div_by_zero, overflow}), 64'(snap));
        end
        @(posedge clk);
        #1 ready_mode = 1;
        @(negedge clk);
        check("bp_in_ready_pre_hs", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of BUSY drops the operation.
        send(100, 7, 1'b0, lat);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        send(255, 16, 1'b1, lat);
        check("lat_255_16", 64'(lat), 64'd9);

        // Random operands with random consumer backpressure.
        @(posedge clk);
        #1 ready_mode = 0;
        for (int i = 0; i < 60; i++) begin
            int unsigned dvd;
            int unsigned dvs;
            dvd = $urandom_range(0, 65535);
            case ($urandom_range(0, 5))
                0: dvs = 0;
                1: dvs = $urandom_range(1, 255);
                2: dvs = $urandom_range(1, 15);
                default: dvs = $urandom_range(dvd / 256 + 1 > 255 ? 255 : dvd / 256 + 1, 255);
            endcase
            send(dvd, dvs, 1'b0, lat);
        end

        @(posedge clk);
        #1 ready_mode = 1;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        // WIDTH=512 round-trip of a multiplier product back to its operand.
        prod = 1024'(32'h5829EC10) * 1024'(32'h123BBBCF);
        @(negedge clk);
        b_dividend = prod;
        b_divisor  = 512'(32'h5829EC10);
        b_in_valid = 1'b1;
        check("big_in_ready", 64'(b_in_ready), 64'd1);
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        lat = 1;
        guard = 0;
        while (guard < 700) begin
            @(negedge clk);
            if (b_out_valid) break;
            @(posedge clk);
            lat++;
            guard++;
        end
        check("big_latency", 64'(lat), 64'd513);
        check("big_quotient_hi", 64'(b_quotient[511:32] != '0), 64'd0);
        check("big_quotient_lo", 64'(b_quotient[31:0]), 64'h123BBBCF);
        check("big_remainder", 64'(b_remainder != '0), 64'd0);
        check("big_flags", 64'({b_dbz, b_ovf}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
